// File: rtl/dq_stream_serializer.sv
// dq_stream_serializer
// Width-down converter for the dequantized QDQ output stream. Each wide input
// beat holds one tile row of LANES_NUM FP words. The row is emitted as
// LANES_NUM/OUT_LANES narrow beats, lowest lanes first. Row and slice position
// are tracked so that the final narrow beat of every MAT_SIZE-row tile carries
// m_last_o, and completed tiles are counted.

module dq_stream_serializer #(
    parameter int LANES_NUM  = 16,
    parameter int FP_DATA_W  = 32,
    parameter int OUT_LANES  = 4,
    parameter int MAT_SIZE   = 16,
    parameter int TILE_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rstnn,
    input  logic                            clear_i,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    input  logic [LANES_NUM*FP_DATA_W-1:0]  s_data_i,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [OUT_LANES*FP_DATA_W-1:0]  m_data_o,
    output logic                            m_last_o,
    output logic [TILE_CNT_W-1:0]           tile_cnt_o,
    output logic                            busy_o
);

    localparam int R       = LANES_NUM / OUT_LANES;
    localparam int IN_W    = LANES_NUM * FP_DATA_W;
    localparam int OUT_W   = OUT_LANES * FP_DATA_W;
    localparam int SLICE_W = (R > 1) ? $clog2(R) : 1;
    localparam int ROW_W   = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(R - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(MAT_SIZE - 1);

    // A wide beat must split into a whole number of narrow beats.
    generate
        if ((LANES_NUM % OUT_LANES) != 0) begin : g_bad_ratio
            $error("dq_stream_serializer: LANES_NUM must be a multiple of OUT_LANES");
        end
    endgenerate

    logic                  hold_v;
    logic [IN_W-1:0]       hold_data;
    logic [SLICE_W-1:0]    slice_cnt;
    logic [ROW_W-1:0]      row_cnt;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic [OUT_W-1:0]      slice_data;

    logic pop;
    logic at_slice_last;
    logic pop_end;
    logic load;
    logic last_beat;

    assign at_slice_last = (slice_cnt == SLICE_LAST);
    assign pop           = hold_v & m_ready_i;
    assign pop_end       = pop & at_slice_last;
    // Ready also opens while the last slice is leaving, so rows follow back-to-back.
    assign s_ready_o     = ~clear_i & (~hold_v | pop_end);
    assign load          = s_valid_i & s_ready_o;
    assign last_beat     = hold_v & at_slice_last & (row_cnt == ROW_LAST);

    assign m_valid_o  = hold_v;
    assign m_data_o   = slice_data;
    assign m_last_o   = last_beat;
    assign tile_cnt_o = tile_cnt;
    assign busy_o     = hold_v | (row_cnt != '0);

    // Select the slice of the held row that is currently on offer.
    always_comb begin
        slice_data = '0;
        for (int j = 0; j < R; j++) begin
            if (slice_cnt == SLICE_W'(j)) begin
                slice_data = hold_data[j*OUT_W +: OUT_W];
            end
        end
    end

    // Held row register plus slice/row/tile position; clear beats everything.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            hold_v    <= 1'b0;
            hold_data <= '0;
            slice_cnt <= '0;
            row_cnt   <= '0;
            tile_cnt  <= '0;
        end else if (clear_i) begin
            hold_v    <= 1'b0;
            slice_cnt <= '0;
            row_cnt   <= '0;
            tile_cnt  <= '0;
        end else begin
            if (pop) begin
                if (at_slice_last) begin
                    slice_cnt <= '0;
                    row_cnt   <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    slice_cnt <= slice_cnt + SLICE_W'(1);
                end
                if (last_beat) begin
                    tile_cnt <= tile_cnt + TILE_CNT_W'(1);
                end
            end
            if (load) begin
                hold_data <= s_data_i;
                hold_v    <= 1'b1;
                slice_cnt <= '0;
            end else if (pop_end) begin
                hold_v <= 1'b0;
            end
        end
    end

endmodule
